// File: rtl/axi_lite_ram_slave_pkg.sv
// Shared response codes and FSM state types for the AXI4-Lite RAM responder.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ACCESS,
        R_RESP
    } r_state_e;

endpackage

// File: rtl/axi_lite_ram_slave_if.sv
// AXI4-Lite AW/W/B/AR/R channel bundle; master drives requests, slave drives responses.
interface axi_lite_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_ram_array.sv
// Byte-enabled single-write / single-read synchronous RAM; a read colliding with a
// write on the same edge returns the old contents.
module axi_lite_ram_array #(
    parameter int  DATA_WIDTH = 64,
    parameter int  MEM_WORDS  = 4096,
    localparam int IDX_W      = $clog2(MEM_WORDS),
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_W-1:0]     wstrb,
    input  logic                  re,
    input  logic [IDX_W-1:0]      ridx,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // NOTE: the array has no reset so it maps onto block RAM; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[ridx];
        end
        if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite responder over a byte-enabled RAM: one outstanding write and one
// outstanding read, served by independent FSMs.
module axi_lite_ram_slave
    import axi_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    MEM_WORDS  = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 64'h0
) (
    input logic         clk,
    input logic         rstn,
    axi_lite_if.slave   bus
);

    localparam int STRB_W     = DATA_WIDTH / 8;
    localparam int LANE_SHIFT = $clog2(STRB_W);
    localparam int IDX_W      = $clog2(MEM_WORDS);

    function automatic logic in_range(logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] word;
        word = (a - BASE_ADDR) >> LANE_SHIFT;
        return (a >= BASE_ADDR) && (word < ADDR_WIDTH'(MEM_WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> LANE_SHIFT);
    endfunction

    logic rst_done;

    w_state_e              w_state, w_next;
    logic                  aw_held, w_held, b_err;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]     w_strb;
    logic                  aw_ready, w_ready, commit;
    logic [ADDR_WIDTH-1:0] addr_eff;
    logic [DATA_WIDTH-1:0] data_eff;
    logic [STRB_W-1:0]     strb_eff;

    r_state_e              r_state, r_next;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_ok, ar_ready, ram_re;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) rst_done <= 1'b0;
        else       rst_done <= 1'b1;
    end

    // A beat arriving in the commit cycle itself is forwarded straight from the bus.
    assign addr_eff = aw_held ? aw_addr : bus.awaddr;
    assign data_eff = w_held  ? w_data  : bus.wdata;
    assign strb_eff = w_held  ? w_strb  : bus.wstrb;

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        w_next   = w_state;
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        commit   = 1'b0;
        case (w_state)
            W_IDLE: begin
                aw_ready = rst_done & ~aw_held;
                w_ready  = rst_done & ~w_held;
                if ((aw_held | (bus.awvalid & aw_ready)) & (w_held | (bus.wvalid & w_ready))) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_RESP: if (bus.bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_state <= W_IDLE;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            b_err   <= 1'b0;
        end else begin
            w_state <= w_next;
            if (bus.awvalid & aw_ready) aw_held <= 1'b1;
            if (bus.wvalid & w_ready)   w_held  <= 1'b1;
            if (commit)                 b_err   <= ~in_range(addr_eff);
            if ((w_state == W_RESP) && bus.bready) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    // Payload registers are only meaningful while their held/valid flag is set.
    always_ff @(posedge clk) begin
        if (bus.awvalid & aw_ready) aw_addr <= bus.awaddr;
        if (bus.wvalid & w_ready) begin
            w_data <= bus.wdata;
            w_strb <= bus.wstrb;
        end
        if ((r_state == R_IDLE) && bus.arvalid && ar_ready) r_idx <= idx_of(bus.araddr);
    end

    always_comb begin
        r_next   = r_state;
        ar_ready = 1'b0;
        ram_re   = 1'b0;
        case (r_state)
            R_IDLE: begin
                ar_ready = rst_done;
                if (bus.arvalid & ar_ready) r_next = R_ACCESS;
            end
            R_ACCESS: begin
                ram_re = 1'b1;
                r_next = R_RESP;
            end
            R_RESP: if (bus.rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= R_IDLE;
            r_ok    <= 1'b0;
        end else begin
            r_state <= r_next;
            if ((r_state == R_IDLE) && bus.arvalid && ar_ready) r_ok <= in_range(bus.araddr);
        end
    end

    axi_lite_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (commit & in_range(addr_eff)),
        .widx  (idx_of(addr_eff)),
        .wdata (data_eff),
        .wstrb (strb_eff),
        .re    (ram_re),
        .ridx  (r_idx),
        .rdata (ram_rdata)
    );

    assign bus.awready = aw_ready;
    assign bus.wready  = w_ready;
    assign bus.bvalid  = (w_state == W_RESP);
    assign bus.bresp   = b_err ? RESP_SLVERR : RESP_OKAY;
    assign bus.arready = ar_ready;
    assign bus.rvalid  = (r_state == R_RESP);
    assign bus.rdata   = ((r_state == R_RESP) && r_ok) ? ram_rdata : '0;
    assign bus.rresp   = ((r_state == R_RESP) && !r_ok) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Self-checking bench: vector table, hand-written timing sequences and a randomized
// phase checked against a word-array memory model.
module tb_axi_lite_ram_slave;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    axi_lite_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

    axi_lite_ram_slave #(
        .ADDR_WIDTH (64),
        .DATA_WIDTH (64),
        .MEM_WORDS  (4096),
        .BASE_ADDR  (64'h0)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] waddr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [1:0]  bresp;
        logic [63:0] raddr;
        logic [63:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    vec_t        vecs [9];
    logic [63:0] model [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] nw, logic [7:0] s);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    task automatic axi_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                             output logic [1:0] resp, output int lat);
        logic aw_done, w_done, aw_now, w_now;
        int   n;
        bus.awaddr = a; bus.awvalid = 1'b1;
        bus.wdata = d;  bus.wstrb = s; bus.wvalid = 1'b1;
        bus.bready = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            @(negedge clk);
            aw_now = bus.awvalid && bus.awready;
            w_now  = bus.wvalid && bus.wready;
            @(posedge clk); #1;
            if (aw_now) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
            if (w_now)  begin w_done  = 1'b1; bus.wvalid  = 1'b0; end
            n++;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("wr_handshake", {62'b0, aw_done, w_done}, 64'd3);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.bvalid) break;
        end
        resp = bus.bresp;
        @(posedge clk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [63:0] a, output logic [63:0] d,
                            output logic [1:0] resp, output int lat);
        logic done;
        int   n;
        bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
        done = 1'b0; n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            done = bus.arready;
            @(posedge clk); #1;
            n++;
        end
        bus.arvalid = 1'b0;
        check("rd_handshake", {63'b0, done}, 64'd1);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.rvalid) break;
        end
        d = bus.rdata; resp = bus.rresp;
        @(posedge clk); #1;
        bus.rready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before the end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  resp;
        logic [63:0] rd;
        int          lat;

        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        vecs[0] = '{64'h10, 64'h1122334455667788, 8'hFF, 2'b00, 64'h10, 64'h1122334455667788, 2'b00};
        vecs[1] = '{64'h00, 64'hDEADBEEF0BADF00D, 8'hFF, 2'b00, 64'h00, 64'hDEADBEEF0BADF00D, 2'b00};
        vecs[2] = '{64'h18, 64'h0102030405060708, 8'hFF, 2'b00, 64'h1F, 64'h0102030405060708, 2'b00};
        vecs[3] = '{64'h18, 64'hFFFFFFFFFFFFFFFF, 8'h00, 2'b00, 64'h18, 64'h0102030405060708, 2'b00};
        vecs[4] = '{64'h18, 64'hA0B0C0D0E0F01020, 8'hA5, 2'b00, 64'h18, 64'hA002C00405F00720, 2'b00};
        vecs[5] = '{64'h8000, 64'h123456789ABCDEF0, 8'hFF, 2'b10, 64'h8000, 64'h0, 2'b10};
        vecs[6] = '{64'hFFFFFFFFFFFFFFF8, 64'h5555555555555555, 8'hFF, 2'b10, 64'h00, 64'hDEADBEEF0BADF00D, 2'b00};
        vecs[7] = '{64'h7FF8, 64'h0F0E0D0C0B0A0908, 8'hFF, 2'b00, 64'h7FF8, 64'h0F0E0D0C0B0A0908, 2'b00};
        vecs[8] = '{64'h20, 64'h0000000000000077, 8'hFF, 2'b00, 64'h20, 64'h0000000000000077, 2'b00};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valids", {62'b0, bus.bvalid, bus.rvalid}, 64'd0);
        check("reset_readys", {61'b0, bus.awready, bus.wready, bus.arready}, 64'd0);
        check("reset_resp_data", {bus.rdata[59:0], bus.bresp, bus.rresp}, 64'd0);
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        check("first_cycle_readys", {61'b0, bus.awready, bus.wready, bus.arready}, 64'd0);
        @(negedge clk);
        check("idle_readys", {61'b0, bus.awready, bus.wready, bus.arready}, 64'd7);
        @(posedge clk); #1;

        // Vector table: each entry is a write followed by a read
        for (int i = 0; i < 9; i++) begin
            axi_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, resp, lat);
            check($sformatf("vec%0d_bresp", i), 64'(resp), 64'(vecs[i].bresp));
            check($sformatf("vec%0d_b_latency", i), 64'(lat), 64'd1);
            axi_read(vecs[i].raddr, rd, resp, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("vec%0d_rresp", i), 64'(resp), 64'(vecs[i].rresp));
            check($sformatf("vec%0d_r_latency", i), 64'(lat), 64'd2);
        end

        // W three cycles ahead of AW, low-half strobe
        bus.wdata = 64'hAAAAAAAAAAAAAAAA; bus.wstrb = 8'h0F; bus.wvalid = 1'b1; bus.bready = 1'b1;
        @(negedge clk);
        check("split_wready", {63'b0, bus.wready}, 64'd1);
        @(posedge clk); #1 bus.wvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("split_no_bvalid", {63'b0, bus.bvalid}, 64'd0);
            check("split_readys_w_held", {62'b0, bus.awready, bus.wready}, 64'd2);
        end
        @(posedge clk); #1 bus.awaddr = 64'h10; bus.awvalid = 1'b1;
        @(negedge clk);
        check("split_awready", {63'b0, bus.awready}, 64'd1);
        @(posedge clk); #1 bus.awvalid = 1'b0;
        @(negedge clk);
        check("split_bvalid", {63'b0, bus.bvalid}, 64'd1);
        check("split_bresp", 64'(bus.bresp), 64'd0);
        @(posedge clk); #1 bus.bready = 1'b0;
        axi_read(64'h10, rd, resp, lat);
        check("split_readback", rd, 64'h11223344AAAAAAAA);

        // Backpressure on both response channels
        bus.awaddr = 64'h28; bus.awvalid = 1'b1; bus.wdata = 64'h0123456789ABCDEF;
        bus.wstrb = 8'hFF; bus.wvalid = 1'b1; bus.araddr = 64'h10; bus.arvalid = 1'b1;
        bus.bready = 1'b0; bus.rready = 1'b0;
        @(negedge clk);
        check("bp_readys_before", {61'b0, bus.awready, bus.wready, bus.arready}, 64'd7);
        @(posedge clk); #1 bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        @(negedge clk);
        check("bp_b_first", {62'b0, bus.bvalid, bus.rvalid}, 64'd2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valids_held", {62'b0, bus.bvalid, bus.rvalid}, 64'd3);
            check("bp_rdata_held", bus.rdata, 64'h11223344AAAAAAAA);
            check("bp_resps_held", {60'b0, bus.bresp, bus.rresp}, 64'd0);
            check("bp_readys_low", {61'b0, bus.awready, bus.wready, bus.arready}, 64'd0);
        end
        bus.bready = 1'b1; bus.rready = 1'b1;
        @(posedge clk); #1 bus.bready = 1'b0; bus.rready = 1'b0;
        @(negedge clk);
        check("bp_valids_cleared", {62'b0, bus.bvalid, bus.rvalid}, 64'd0);
        check("bp_readys_after", {61'b0, bus.awready, bus.wready, bus.arready}, 64'd7);
        @(posedge clk); #1;
        axi_read(64'h28, rd, resp, lat);
        check("bp_write_readback", rd, 64'h0123456789ABCDEF);

        // Read access and write commit to 0x20 on the same edge
        bus.araddr = 64'h20; bus.arvalid = 1'b1; bus.rready = 1'b1;
        @(negedge clk);
        check("coll_arready", {63'b0, bus.arready}, 64'd1);
        @(posedge clk); #1 bus.arvalid = 1'b0;
        bus.awaddr = 64'h20; bus.awvalid = 1'b1; bus.wdata = 64'h5; bus.wstrb = 8'hFF;
        bus.wvalid = 1'b1; bus.bready = 1'b1;
        @(negedge clk);
        check("coll_aw_w_ready", {62'b0, bus.awready, bus.wready}, 64'd3);
        @(posedge clk); #1 bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk);
        check("coll_valids", {62'b0, bus.bvalid, bus.rvalid}, 64'd3);
        check("coll_old_data", bus.rdata, 64'h77);
        @(posedge clk); #1 bus.bready = 1'b0; bus.rready = 1'b0;
        axi_read(64'h20, rd, resp, lat);
        check("coll_new_data", rd, 64'h5);

        // Reset while W is held and the read sits in its response phase
        bus.wdata = 64'hBADBADBADBADBAD0; bus.wstrb = 8'hFF; bus.wvalid = 1'b1;
        bus.araddr = 64'h10; bus.arvalid = 1'b1;
        @(negedge clk);
        check("rst_setup_readys", {62'b0, bus.wready, bus.arready}, 64'd3);
        @(posedge clk); #1 bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_setup_state", {62'b0, bus.rvalid, bus.wready}, 64'd2);
        rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        check("rst_mid_valids", {62'b0, bus.bvalid, bus.rvalid}, 64'd0);
        check("rst_mid_readys", {61'b0, bus.awready, bus.wready, bus.arready}, 64'd0);
        check("rst_mid_rdata", bus.rdata, 64'd0);
        @(negedge clk);
        check("rst_mid_readys_back", {61'b0, bus.awready, bus.wready, bus.arready}, 64'd7);
        @(posedge clk); #1 bus.awaddr = 64'h20; bus.awvalid = 1'b1; bus.bready = 1'b1;
        @(negedge clk);
        check("rst_aw_ready", {63'b0, bus.awready}, 64'd1);
        @(posedge clk); #1 bus.awvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst_no_stale_commit", {63'b0, bus.bvalid}, 64'd0);
        end
        @(posedge clk); #1 bus.wdata = 64'hFFFFFFFFFFFFFFFF; bus.wstrb = 8'h00; bus.wvalid = 1'b1;
        @(negedge clk);
        check("rst_w_ready", {63'b0, bus.wready}, 64'd1);
        @(posedge clk); #1 bus.wvalid = 1'b0;
        @(negedge clk);
        check("rst_zero_strb_bvalid", {61'b0, bus.bvalid, bus.bresp}, 64'd4);
        @(posedge clk); #1 bus.bready = 1'b0;
        axi_read(64'h20, rd, resp, lat);
        check("rst_word_unchanged", rd, 64'h5);

        // Randomized traffic against the word-array model
        for (int i = 0; i < 16; i++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            axi_write(64'h200 + 64'(i) * 8, d, 8'hFF, resp, lat);
            model[i] = d;
            check("rand_init_bresp", 64'(resp), 64'd0);
        end
        for (int k = 0; k < 60; k++) begin
            int          w;
            logic        oor;
            logic [63:0] a, d, exp_d;
            logic [7:0]  s;
            w   = $urandom_range(0, 15);
            oor = ($urandom_range(0, 7) == 0);
            a   = oor ? 64'h8000 + 64'($urandom_range(0, 1023)) * 8 + 64'($urandom_range(0, 7))
                      : 64'h200 + 64'(w) * 8 + 64'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) begin
                d = {$urandom, $urandom};
                s = 8'($urandom);
                axi_write(a, d, s, resp, lat);
                if (!oor) model[w] = merge(model[w], d, s);
                check("rand_bresp", 64'(resp), oor ? 64'd2 : 64'd0);
                check("rand_b_latency", 64'(lat), 64'd1);
            end else begin
                exp_d = oor ? 64'd0 : model[w];
                axi_read(a, rd, resp, lat);
                check("rand_rdata", rd, exp_d);
                check("rand_rresp", 64'(resp), oor ? 64'd2 : 64'd0);
                check("rand_r_latency", 64'(lat), 64'd2);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
